// File: rtl/perf_report_pkg.sv
// Shared types and frame-geometry helpers for the performance-report sequencer.
package perf_report_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam logic [7:0] DEF_HEADER = 8'hA5;

  // Frame = header + payload bytes + checksum.
  function automatic int frame_len(input int num_cnt, input int cnt_w);
    return 2 + (num_cnt * cnt_w) / 8;
  endfunction

  function automatic int idx_width(input int num_cnt, input int cnt_w);
    return $clog2(frame_len(num_cnt, cnt_w));
  endfunction

endpackage

// File: rtl/report_tick_gen.sv
// Free-running periodic tick: pulses for one cycle every PERIOD cycles; PERIOD=0 disables it.
module report_tick_gen #(
  parameter int PERIOD = 0
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  generate
    if (PERIOD == 0) begin : g_off
      logic unused_in;
      assign unused_in = clk ^ rst;
      assign tick      = 1'b0;
    end else begin : g_on
      localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
      localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
      logic [CW-1:0] cnt;

      always_ff @(posedge clk) begin
        if (rst)              cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
      end

      assign tick = (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/perf_report_sequencer.sv
// Snapshots the counter bank on a trigger/tick and streams a framed report
// (header, counters MSB-first, XOR checksum) over a ready/valid byte port.
module perf_report_sequencer
  import perf_report_pkg::*;
#(
  parameter int         NUM_CNT = 8,
  parameter int         CNT_W   = 32,
  parameter logic [7:0] HEADER  = DEF_HEADER,
  parameter int         PERIOD  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trigger,
  input  logic [NUM_CNT*CNT_W-1:0] cnt_flat,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun
);

  localparam int BPC   = CNT_W / 8;
  localparam int PAY_N = NUM_CNT * BPC;
  localparam int L     = frame_len(NUM_CNT, CNT_W);
  localparam int IDX_W = idx_width(NUM_CNT, CNT_W);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(L - 1);

  state_e                     state, state_nxt;
  logic [IDX_W-1:0]           idx;
  logic [NUM_CNT*CNT_W-1:0]   snap;
  logic [7:0]                 csum;
  logic [PAY_N-1:0][7:0]      pay;
  logic [7:0]                 byte_sel;
  logic                       tick, go, xfer, last;

  report_tick_gen #(.PERIOD(PERIOD)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign go   = trigger | tick;
  assign xfer = (state == ST_SEND) && tx_ready;
  assign last = (idx == LAST);

  // Payload byte p is byte (p % BPC) of counter (p / BPC), most significant first.
  genvar p;
  generate
    for (p = 0; p < PAY_N; p++) begin : g_pay
      assign pay[p] = snap[(p / BPC) * CNT_W + (BPC - 1 - (p % BPC)) * 8 +: 8];
    end
  endgenerate

  // Selection mux keyed on idx; the snapshot never shifts, so data holds under backpressure.
  always_comb begin
    byte_sel = HEADER;
    if (last) begin
      byte_sel = csum;
    end else begin
      for (int k = 0; k < PAY_N; k++)
        if (idx == IDX_W'(k + 1)) byte_sel = pay[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    case (state)
      ST_IDLE: begin
        if (go) state_nxt = ST_SEND;
      end
      ST_SEND: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = byte_sel;
        if (xfer && last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && go) snap <= cnt_flat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      csum       <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= xfer && last;
      if (state == ST_IDLE && go) begin
        idx  <= '0;
        csum <= '0;
      end else if (xfer) begin
        idx  <= idx + 1'b1;
        csum <= csum ^ byte_sel;
      end
      if (state == ST_SEND && go) overrun <= 1'b1;
    end
  end

endmodule
